fifo_driver: RTL and testbench

FIFO_DRIVER -- requirements
Module: fifo_driver

---
 rtl/fifo_driver.sv | 158 +++++++++++++++
 tb/tb_fifo_driver.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_driver.sv
// Command-driven burst engine for a synchronous FIFO: issues WRITE/READ opcodes,
// tracks a shadow occupancy, and captures read data with a running XOR checksum.
module fifo_driver #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  CmdValid,
    output logic                  CmdReady,
    input  logic                  CmdDir,
    input  logic [4:0]            CmdLen,
    input  logic [DATA_WIDTH-1:0] CmdData,
    output logic [1:0]            OpCode,
    output logic [DATA_WIDTH-1:0] Din,
    input  logic [DATA_WIDTH-1:0] Dout,
    output logic                  RdValid,
    output logic [DATA_WIDTH-1:0] RdData,
    output logic                  Done,
    output logic                  Error,
    output logic [4:0]            Level,
    output logic [DATA_WIDTH-1:0] Checksum
);

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE
    } state_e;

    localparam logic [1:0] OP_IDLE  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [5:0] DEPTH6   = 6'(DEPTH);
    localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    state_e                state_q, state_d;
    logic [4:0]            cnt_q, cnt_d;
    logic                  drain_q, drain_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic [4:0]            level_q, level_d;
    logic                  err_q, err_d;
    logic                  rd_pend_q, rd_pend_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [DATA_WIDTH-1:0] csum_q, csum_d;
    logic [1:0]            op;
    logic                  reject;

    // Capacity checks use 6 bits so Level+CmdLen cannot wrap.
    always_comb begin
        reject = (CmdLen == 5'd0) || ({1'b0, CmdLen} > DEPTH6) ||
                 (!CmdDir && (({1'b0, level_q} + {1'b0, CmdLen}) > DEPTH6)) ||
                 (CmdDir && (CmdLen > level_q));
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        drain_d    = drain_q;
        din_d      = din_q;
        level_d    = level_q;
        err_d      = 1'b0;
        op         = OP_IDLE;
        rd_valid_d = rd_pend_q;
        rd_data_d  = rd_data_q;
        csum_d     = csum_q;

        if (rd_pend_q) begin
            rd_data_d = Dout;
            csum_d    = csum_q ^ Dout;
        end

        case (state_q)
            S_IDLE: begin
                if (CmdValid) begin
                    if (reject) begin
                        err_d = 1'b1;
                    end else begin
                        cnt_d = CmdLen;
                        if (CmdDir) begin
                            state_d = S_READ;
                            csum_d  = '0;
                        end else begin
                            state_d = S_WRITE;
                            din_d   = CmdData;
                        end
                    end
                end
            end
            S_WRITE: begin
                op      = OP_WRITE;
                level_d = level_q + 5'd1;
                // Din stops advancing on the last word so it holds outside WRITE.
                if (cnt_q == 5'd1) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                    din_d = din_q + ONE;
                end
            end
            S_READ: begin
                op      = OP_READ;
                level_d = level_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = S_DRAIN;
                    drain_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            S_DRAIN: begin
                // Two cycles lets the last read word reach RdData before Done.
                if (drain_q) state_d = S_DONE;
                drain_d = 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        rd_pend_d = (op == OP_READ);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            drain_q    <= 1'b0;
            din_q      <= '0;
            level_q    <= '0;
            err_q      <= 1'b0;
            rd_pend_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            csum_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            drain_q    <= drain_d;
            din_q      <= din_d;
            level_q    <= level_d;
            err_q      <= err_d;
            rd_pend_q  <= rd_pend_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            csum_q     <= csum_d;
        end
    end

    assign CmdReady = (state_q == S_IDLE);
    assign OpCode   = op;
    assign Din      = din_q;
    assign RdValid  = rd_valid_q;
    assign RdData   = rd_data_q;
    assign Done     = (state_q == S_DONE);
    assign Error    = err_q;
    assign Level    = level_q;
    assign Checksum = csum_q;

endmodule

// File: tb/tb_fifo_driver.sv
// Directed bench for fifo_driver with a small behavioural FIFO on the opcode bus.
module tb_fifo_driver;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        CmdValid;
    logic        CmdReady;
    logic        CmdDir;
    logic [4:0]  CmdLen;
    logic [31:0] CmdData;
    logic [1:0]  OpCode;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        RdValid;
    logic [31:0] RdData;
    logic        Done;
    logic        Error;
    logic [4:0]  Level;
    logic [31:0] Checksum;

    int n_cmp = 0;
    int n_bad = 0;

    fifo_driver #(.DEPTH(16), .DATA_WIDTH(32)) dut (
        .Clk(Clk), .Reset(Reset), .CmdValid(CmdValid), .CmdReady(CmdReady),
        .CmdDir(CmdDir), .CmdLen(CmdLen), .CmdData(CmdData), .OpCode(OpCode),
        .Din(Din), .Dout(Dout), .RdValid(RdValid), .RdData(RdData),
        .Done(Done), .Error(Error), .Level(Level), .Checksum(Checksum)
    );

    always #5 Clk = ~Clk;

    // FIFO stand-in: Dout valid the cycle after a READ is sampled.
    logic [31:0] mem [0:15];
    logic [3:0]  wp, rp;
    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wp   <= '0;
            rp   <= '0;
            Dout <= '0;
        end else begin
            if (OpCode == 2'b01) begin
                mem[wp] <= Din;
                wp      <= wp + 4'd1;
            end
            if (OpCode == 2'b10) begin
                Dout <= mem[rp];
                rp   <= rp + 4'd1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic cmd(input logic dir, input logic [4:0] len, input logic [31:0] data);
        CmdValid = 1'b1;
        CmdDir   = dir;
        CmdLen   = len;
        CmdData  = data;
        tick();
        CmdValid = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (!Done && n < bound) begin
            tick();
            n++;
        end
        chk("done_wait", {31'd0, Done}, 32'd1);
    endtask

    initial begin
        Reset = 1'b1; CmdValid = 1'b0; CmdDir = 1'b0; CmdLen = '0; CmdData = '0;
        tick(); tick();
        chk("rst_op", {30'd0, OpCode}, 32'd0);
        chk("rst_lvl", {27'd0, Level}, 32'd0);
        chk("rst_din", Din, 32'd0);
        chk("rst_rdv", {31'd0, RdValid}, 32'd0);
        chk("rst_done", {31'd0, Done}, 32'd0);
        chk("rst_err", {31'd0, Error}, 32'd0);
        chk("rst_csum", Checksum, 32'd0);
        Reset = 1'b0;
        tick();
        chk("rdy_after_rst", {31'd0, CmdReady}, 32'd1);

        // write 3 words from 0x10
        cmd(1'b0, 5'd3, 32'h10);
        chk("w3_op0", {30'd0, OpCode}, 32'd1); chk("w3_din0", Din, 32'h10);
        chk("w3_rdy", {31'd0, CmdReady}, 32'd0);
        tick(); chk("w3_op1", {30'd0, OpCode}, 32'd1); chk("w3_din1", Din, 32'h11);
        chk("w3_lvl1", {27'd0, Level}, 32'd1);
        tick(); chk("w3_op2", {30'd0, OpCode}, 32'd1); chk("w3_din2", Din, 32'h12);
        tick(); chk("w3_op3", {30'd0, OpCode}, 32'd0); chk("w3_done", {31'd0, Done}, 32'd1);
        chk("w3_lvl", {27'd0, Level}, 32'd3);
        tick(); chk("w3_done_end", {31'd0, Done}, 32'd0); chk("w3_rdy_end", {31'd0, CmdReady}, 32'd1);

        // read 3 words back
        cmd(1'b1, 5'd3, 32'h0);
        chk("r3_op0", {30'd0, OpCode}, 32'd2); chk("r3_rdv0", {31'd0, RdValid}, 32'd0);
        tick(); chk("r3_op1", {30'd0, OpCode}, 32'd2); chk("r3_rdv1", {31'd0, RdValid}, 32'd0);
        tick(); chk("r3_op2", {30'd0, OpCode}, 32'd2); chk("r3_rdv2", {31'd0, RdValid}, 32'd1);
        chk("r3_data0", RdData, 32'h10);
        tick(); chk("r3_op3", {30'd0, OpCode}, 32'd0); chk("r3_data1", RdData, 32'h11);
        chk("r3_lvl", {27'd0, Level}, 32'd0);
        tick(); chk("r3_rdv4", {31'd0, RdValid}, 32'd1); chk("r3_data2", RdData, 32'h12);
        chk("r3_nodone", {31'd0, Done}, 32'd0);
        tick(); chk("r3_done", {31'd0, Done}, 32'd1); chk("r3_rdv5", {31'd0, RdValid}, 32'd0);
        chk("r3_hold", RdData, 32'h12); chk("r3_csum", Checksum, 32'h13);
        tick();

        // fill to 16, with ignored CmdValid mid-burst
        cmd(1'b0, 5'd16, 32'h100);
        for (int i = 0; i < 16; i++) begin
            chk("w16_op", {30'd0, OpCode}, 32'd1);
            chk("w16_din", Din, 32'h100 + i);
            chk("w16_noerr", {31'd0, Error}, 32'd0);
            if (i == 4) begin CmdValid = 1'b1; CmdDir = 1'b0; CmdLen = 5'd0; end
            if (i == 12) CmdValid = 1'b0;
            tick();
        end
        chk("w16_done", {31'd0, Done}, 32'd1); chk("w16_lvl", {27'd0, Level}, 32'd16);
        chk("w16_noerr_done", {31'd0, Error}, 32'd0);
        tick();
        cmd(1'b0, 5'd1, 32'h55);
        chk("full_err", {31'd0, Error}, 32'd1); chk("full_op", {30'd0, OpCode}, 32'd0);
        chk("full_lvl", {27'd0, Level}, 32'd16); chk("full_rdy", {31'd0, CmdReady}, 32'd1);
        tick(); chk("full_err_end", {31'd0, Error}, 32'd0); chk("full_op2", {30'd0, OpCode}, 32'd0);

        // drain 13 words to leave Level=3; checksum cleared at accept
        cmd(1'b1, 5'd13, 32'h0);
        chk("r13_csum_clr", Checksum, 32'd0); chk("r13_op", {30'd0, OpCode}, 32'd2);
        wait_done(30);
        chk("r13_csum", Checksum, 32'h10C); chk("r13_lvl", {27'd0, Level}, 32'd3);
        tick();

        cmd(1'b1, 5'd5, 32'h0);
        chk("rd5_err", {31'd0, Error}, 32'd1); chk("rd5_op", {30'd0, OpCode}, 32'd0);
        chk("rd5_lvl", {27'd0, Level}, 32'd3);
        tick();
        cmd(1'b0, 5'd0, 32'h0);
        chk("wr0_err", {31'd0, Error}, 32'd1); chk("wr0_op", {30'd0, OpCode}, 32'd0);
        tick();
        cmd(1'b1, 5'd17, 32'h0);
        chk("rd17_err", {31'd0, Error}, 32'd1); chk("rd17_op", {30'd0, OpCode}, 32'd0);
        chk("rd17_lvl", {27'd0, Level}, 32'd3);
        tick();

        // data wrap
        cmd(1'b0, 5'd2, 32'hFFFF_FFFF);
        chk("wrap_din0", Din, 32'hFFFF_FFFF);
        tick(); chk("wrap_din1", Din, 32'h0000_0000); chk("wrap_op1", {30'd0, OpCode}, 32'd1);
        tick(); chk("wrap_done", {31'd0, Done}, 32'd1); chk("wrap_lvl", {27'd0, Level}, 32'd5);
        tick(); chk("wrap_hold", Din, 32'h0000_0000);

        // reset mid-burst after the 2nd write cycle
        cmd(1'b0, 5'd8, 32'h200);
        chk("mid_op0", {30'd0, OpCode}, 32'd1);
        tick(); chk("mid_op1", {30'd0, OpCode}, 32'd1);
        tick(); chk("mid_lvl", {27'd0, Level}, 32'd7);
        Reset = 1'b1;
        #1;
        chk("mid_op_rst", {30'd0, OpCode}, 32'd0); chk("mid_lvl_rst", {27'd0, Level}, 32'd0);
        chk("mid_done_rst", {31'd0, Done}, 32'd0);
        tick();
        Reset = 1'b0;
        tick();
        chk("mid_rdy", {31'd0, CmdReady}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("mid_nodone", {31'd0, Done}, 32'd0);
            chk("mid_noop", {30'd0, OpCode}, 32'd0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
